// File: rtl/mole_scheduler.sv
// Mole scheduler: times the random gap before each pop-up, chooses the mole, runs the
// level-dependent hit window and reports each outcome as a one-cycle hit or miss pulse.
module mole_scheduler #(
    parameter int unsigned N_MOLES   = 4,
    parameter int unsigned TW        = 29,
    parameter int unsigned GAP_MIN   = 100_000_000,
    parameter int unsigned GAP_LOG2  = 27,
    parameter int unsigned WIN_BASE  = 100_000_000,
    parameter int unsigned WIN_STEP  = 2_000_000,
    parameter int unsigned WIN_MIN   = 25_000_000,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_1DEA
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [5:0]         level,
    input  logic [N_MOLES-1:0] btn_rise,
    output logic [N_MOLES-1:0] mole,
    output logic               hit,
    output logic               miss,
    output logic [1:0]         phase
);

    localparam int unsigned WW        = TW + 6;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        PH_IDLE = 2'b00,
        PH_GAP  = 2'b01,
        PH_UP   = 2'b10
    } phase_e;

    phase_e             phase_q, phase_d;
    logic [N_MOLES-1:0] mole_q, mole_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [1:0]         prev_q, prev_d;
    logic [TW-1:0]      gap_q, gap_d;
    logic [TW-1:0]      win_q, win_d;

    logic [TW-1:0]      gap_load;
    logic [WW-1:0]      win_prod;
    logic [TW-1:0]      win_load;
    logic [1:0]         cand;
    logic [1:0]         idx;
    logic [N_MOLES-1:0] idx_onehot;
    logic               correct_press;

    // Draws for the next gap, the next mole and the window length at the current level
    always_comb begin
        lfsr_d        = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        gap_load      = TW'(GAP_MIN) + TW'(lfsr_q[GAP_LOG2-1:0]);
        win_prod      = WW'(level) * WW'(WIN_STEP);
        win_load      = ((win_prod + WW'(WIN_MIN)) >= WW'(WIN_BASE))
                        ? TW'(WIN_MIN) : TW'(WW'(WIN_BASE) - win_prod);
        cand          = lfsr_q[1:0];
        idx           = (cand == prev_q) ? cand + 2'd1 : cand;
        idx_onehot    = N_MOLES'(1) << idx;
        correct_press = (btn_rise == mole_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_IDLE;
            mole_q  <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            prev_q  <= 2'd0;
            gap_q   <= '0;
            win_q   <= '0;
        end else begin
            phase_q <= phase_d;
            mole_q  <= mole_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            lfsr_q  <= lfsr_d;
            prev_q  <= prev_d;
            gap_q   <= gap_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        mole_d  = mole_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        prev_d  = prev_q;
        gap_d   = gap_q;
        win_d   = win_q;
        if (!enable) begin
            // Leaving gameplay discards any pending mole silently
            phase_d = PH_IDLE;
            mole_d  = '0;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    phase_d = PH_GAP;
                    gap_d   = gap_load;
                end
                PH_GAP: begin
                    if (gap_q == '0) begin
                        phase_d = PH_UP;
                        mole_d  = idx_onehot;
                        prev_d  = idx;
                        win_d   = win_load;
                    end else begin
                        gap_d = gap_q - TW'(1);
                    end
                end
                PH_UP: begin
                    if ((btn_rise != '0) || (win_q == '0)) begin
                        hit_d   = correct_press;
                        miss_d  = !correct_press;
                        mole_d  = '0;
                        phase_d = PH_GAP;
                        gap_d   = gap_load;
                    end else begin
                        win_d = win_q - TW'(1);
                    end
                end
                default: begin
                    phase_d = PH_IDLE;
                    mole_d  = '0;
                end
            endcase
        end
    end

    assign mole  = mole_q;
    assign hit   = hit_q;
    assign miss  = miss_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: a pop-up level model predicts every output each cycle,
// and directed scenarios pin gap/window lengths, press judging, enable drop and reset.
module tb_mole_scheduler;

    localparam int GAP_MIN  = 4;
    localparam int GAP_LOG2 = 2;
    localparam int WIN_BASE = 10;
    localparam int WIN_STEP = 2;
    localparam int WIN_MIN  = 4;
    localparam logic [31:0] SEED = 32'hACE1_1DEA;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [5:0] level;
    logic [3:0] btn_rise;
    logic [3:0] mole;
    logic       hit;
    logic       miss;
    logic [1:0] phase;

    int n_pass;
    int n_checks;
    bit mon_on;

    mole_scheduler #(
        .N_MOLES  (4),
        .TW       (29),
        .GAP_MIN  (GAP_MIN),
        .GAP_LOG2 (GAP_LOG2),
        .WIN_BASE (WIN_BASE),
        .WIN_STEP (WIN_STEP),
        .WIN_MIN  (WIN_MIN),
        .LFSR_SEED(SEED)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .level   (level),
        .btn_rise(btn_rise),
        .mole    (mole),
        .hit     (hit),
        .miss    (miss),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic int win_cycles(input int lvl);
        int w;
        w = WIN_BASE - lvl * WIN_STEP;
        if (w < WIN_MIN) w = WIN_MIN;
        return w;
    endfunction

    // Model state: 0 idle, 1 waiting for pop-up, 2 mole visible
    logic [31:0] m_lfsr;
    logic [31:0] m_lf;
    int m_state, m_idx, m_prev, m_appear_in, m_left, m_cand;
    bit m_hit, m_miss;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_lfsr = SEED; m_state = 0; m_idx = -1; m_prev = 0;
            m_appear_in = 0; m_left = 0; m_hit = 0; m_miss = 0;
        end else begin
            m_lf   = m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
            m_hit  = 0;
            m_miss = 0;
            if (!enable) begin
                m_state = 0;
                m_idx   = -1;
            end else if (m_state == 0) begin
                m_state     = 1;
                m_appear_in = GAP_MIN + int'(m_lf & ((32'd1 << GAP_LOG2) - 32'd1)) + 1;
            end else if (m_state == 1) begin
                m_appear_in--;
                if (m_appear_in == 0) begin
                    m_cand = int'(m_lf & 32'd3);
                    if (m_cand == m_prev) m_cand = (m_cand + 1) % 4;
                    m_idx   = m_cand;
                    m_prev  = m_cand;
                    m_state = 2;
                    m_left  = win_cycles(int'(level)) + 1;
                end
            end else begin
                if (btn_rise != 4'b0000 || m_left == 1) begin
                    if (btn_rise == 4'(32'd1 << m_idx)) m_hit = 1;
                    else m_miss = 1;
                    m_idx       = -1;
                    m_state     = 1;
                    m_appear_in = GAP_MIN + int'(m_lf & ((32'd1 << GAP_LOG2) - 32'd1)) + 1;
                end else begin
                    m_left--;
                end
            end
        end
    end

    bit prev_pulse;
    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            chk("mon_mole", 32'(mole), (m_idx < 0) ? 32'd0 : (32'd1 << m_idx));
            chk("mon_phase", 32'(phase), 32'(m_state));
            chk("mon_hit", 32'(hit), 32'(m_hit));
            chk("mon_miss", 32'(miss), 32'(m_miss));
            chk("mon_onehot", 32'($countones(mole) <= 1), 32'd1);
            chk("mon_pulse_excl", 32'(hit && miss), 32'd0);
            chk("mon_pulse_b2b", 32'(prev_pulse && (hit || miss)), 32'd0);
            prev_pulse = hit || miss;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_up(input string nm, output int n);
        n = 0;
        while (mole == 4'b0000 && n < 200) begin
            tick();
            n++;
        end
        chk({nm, "_popup_seen"}, 32'(mole != 4'b0000), 32'd1);
    endtask

    task automatic measure_up(input int chg_at, input logic [5:0] chg_lvl, output int k);
        k = 0;
        while (mole != 4'b0000 && k < 100) begin
            tick();
            k++;
            if (chg_at != 0 && k == chg_at) level = chg_lvl;
        end
    endtask

    task automatic press(input logic [3:0] b);
        btn_rise = b;
        tick();
        btn_rise = 4'b0000;
    endtask

    int n, k;
    logic [3:0] prev_mole;
    bit seen [4];

    initial begin
        reset_n = 1'b0; enable = 1'b0; level = 6'd0; btn_rise = 4'b0000;
        mon_on = 0; n_pass = 0; n_checks = 0; prev_pulse = 0;

        chk("pin_lfsr1", lfsr_step(32'hACE1_1DEA), 32'h5670_8EF5);
        chk("pin_lfsr2", lfsr_step(32'h5670_8EF5), 32'hAB18_4779);
        chk("pin_win_l0", 32'(win_cycles(0)), 32'd10);
        chk("pin_win_l2", 32'(win_cycles(2)), 32'd6);
        chk("pin_win_l5", 32'(win_cycles(5)), 32'd4);

        repeat (3) @(posedge clk);
        #1;
        mon_on = 1;
        chk("rst_mole", 32'(mole), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_pulses", 32'(hit | miss), 32'd0);
        reset_n = 1'b1;

        // Enabled off: stays idle
        repeat (20) tick();
        chk("idle_mole", 32'(mole), 32'd0);
        chk("idle_phase", 32'(phase), 32'd0);

        // Untouched pop-up times out after W+1 visible cycles
        enable = 1'b1;
        tick();
        chk("s2_gap_entry", 32'(phase), 32'd1);
        wait_up("s2", n);
        chk("s2_gap_5_to_8", 32'(n >= 5 && n <= 8), 32'd1);
        chk("s2_phase_up", 32'(phase), 32'd2);
        measure_up(0, 6'd0, k);
        chk("s2_up_len", 32'(k), 32'd11);
        chk("s2_timeout_miss", 32'(miss), 32'd1);
        chk("s2_timeout_nohit", 32'(hit), 32'd0);

        // Correct press on third visible cycle, then all buttons, then a wrong single button
        wait_up("s3a", n);
        tick(); tick();
        press(4'(32'd1 << m_idx));
        chk("s3_hit", 32'(hit), 32'd1);
        chk("s3_mole_clr", 32'(mole), 32'd0);
        chk("s3_phase_gap", 32'(phase), 32'd1);
        wait_up("s3b", n);
        press(4'b1111);
        chk("s3_all_miss", 32'(miss), 32'd1);
        chk("s3_all_nohit", 32'(hit), 32'd0);
        wait_up("s3c", n);
        press(4'(32'd1 << ((m_idx + 1) % 4)));
        chk("s3_wrong_miss", 32'(miss), 32'd1);

        // Window scaling with level and clamp at the floor
        level = 6'd5;
        wait_up("s4a", n);
        measure_up(0, 6'd0, k);
        chk("s4_l5_len", 32'(k), 32'd5);
        chk("s4_l5_miss", 32'(miss), 32'd1);
        level = 6'd2;
        wait_up("s4b", n);
        measure_up(2, 6'd5, k);
        chk("s4_l2_midchange_len", 32'(k), 32'd7);
        wait_up("s4c", n);
        measure_up(0, 6'd0, k);
        chk("s4_new_level_len", 32'(k), 32'd5);

        // Long run: no repeats, every mole used, pulses after hits too
        prev_mole = mole;
        for (int i = 0; i < 200; i++) begin
            wait_up("s5", n);
            chk("s5_onehot", 32'($countones(mole)), 32'd1);
            if (i > 0) chk("s5_no_repeat", 32'(mole == prev_mole), 32'd0);
            prev_mole = mole;
            for (int j = 0; j < 4; j++) if (mole[j]) seen[j] = 1;
            if (i % 4 == 1) begin
                press(4'(32'd1 << m_idx));
                chk("s5_hit", 32'(hit), 32'd1);
            end else begin
                measure_up(0, 6'd0, k);
                chk("s5_len", 32'(k), 32'd5);
            end
        end
        for (int j = 0; j < 4; j++) chk("s5_seen", 32'(seen[j]), 32'd1);

        // Enable drop during UP discards the mole without a pulse
        wait_up("s6a", n);
        tick();
        enable = 1'b0;
        tick();
        chk("s6_dis_mole", 32'(mole), 32'd0);
        chk("s6_dis_phase", 32'(phase), 32'd0);
        chk("s6_dis_nopulse", 32'(hit | miss), 32'd0);
        enable = 1'b1;
        tick();
        chk("s6_reenter_gap", 32'(phase), 32'd1);

        // Correct press on the final window cycle is a hit
        wait_up("s6b", n);
        repeat (4) tick();
        chk("s6_last_cycle_up", 32'(mole != 4'b0000), 32'd1);
        press(4'(32'd1 << m_idx));
        chk("s6_last_hit", 32'(hit), 32'd1);
        chk("s6_last_nomiss", 32'(miss), 32'd0);
        chk("s6_last_mole_clr", 32'(mole), 32'd0);

        // Reset mid-UP drops the mole at once
        wait_up("s6c", n);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("s6_rst_mole_async", 32'(mole), 32'd0);
        chk("s6_rst_phase_async", 32'(phase), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) begin
            tick();
            chk("s6_post_rst_nopulse", 32'(hit | miss), 32'd0);
        end

        mon_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
